// File: rtl/uart2stream_pkg.sv
// Shared definitions for the UART <-> byte-stream link.
//  - RX / TX FSM state encodings
//  - Serial frame length (start + 8 data + stop)
//  - Counter width helper for bit-time down-counters
package uart2stream_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBrk
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxShift,
    TxGap
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 10;

  // Width needed for a down-counter that must hold the value div itself.
  function automatic int unsigned cnt_width(input int unsigned div);
    return $clog2(div + 1);
  endfunction

endpackage

// File: rtl/uart2stream_bitcnt.sv
// Loadable bit-time down-counter with an expiry strobe.
// Ports:
//  clk, rst      clock, asynchronous active-high reset
//  i_en          count enable
//  i_load        load i_load_val (wins over counting)
//  i_load_val    value to load
//  o_expire      1-cycle strobe on the last cycle of a period; counter reloads RELOAD
module uart2stream_bitcnt #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned RELOAD = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_cnt;

  // Expiry at 1 (not 0) so a period of N cycles needs a reload value of exactly N.
  assign o_expire = i_en & (r_cnt <= WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= WIDTH'(RELOAD);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (o_expire) begin
      r_cnt <= WIDTH'(RELOAD);
    end else if (i_en) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart2stream.sv
// Host-side UART link for the Wishbone bridge command port.
//  RX: 8N1 deserialiser presenting a valid/ready byte stream.
//  TX: 8N1 serialiser for response bytes, with optional idle gap after the last byte.
// Ports:
//  clk, rst                         clock, asynchronous active-high reset
//  i_uart_rx / o_uart_tx            serial line in (async) / out
//  o_rx_data, o_rx_valid, i_rx_ready   received byte stream
//  i_tx_data, i_tx_last, i_tx_valid, o_tx_ready   byte stream to transmit
//  o_rx_idle                        1-cycle pulse once the line idles IDLE_BITS bit-times
//  o_stat_frame_err, o_stat_overflow   sticky error flags, cleared by i_stat_clr
module uart2stream
  import uart2stream_pkg::*;
#(
  parameter int unsigned DIV       = 48,
  parameter int unsigned TX_GAP    = 0,
  parameter int unsigned IDLE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_rx_idle,
  output logic       o_stat_frame_err,
  output logic       o_stat_overflow,
  input  logic       i_stat_clr
);

  localparam int unsigned CNT_W   = cnt_width(DIV);
  localparam int unsigned IDLE_W  = (IDLE_BITS > 0) ? $clog2(IDLE_BITS + 1) : 1;
  localparam int unsigned GAP_W   = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam bit          IDLE_EN = (IDLE_BITS != 0);

  // ---------------------------------------------------------------- RX sync
  logic       r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0] r_flush;
  logic       r_line_ok;
  logic       w_fall;

  // r_line_ok only rises once a real (post-reset) high has been seen, so a line
  // held low through reset cannot fake a falling edge from the reset values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_flush   <= 2'b00;
      r_line_ok <= 1'b0;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_flush   <= {r_flush[0], 1'b1};
      if (r_flush[1] && r_rx_sync) r_line_ok <= 1'b1;
    end
  end

  assign w_fall = r_line_ok & r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------- RX FSM
  rx_state_e  r_rx_state, w_rx_state_nxt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic       w_rx_exp, w_rx_load, w_byte_done, w_frame_err;

  assign w_rx_load   = (r_rx_state == RxIdle) & w_fall;
  assign w_byte_done = (r_rx_state == RxStop) & w_rx_exp & r_rx_sync;
  assign w_frame_err = (r_rx_state == RxStop) & w_rx_exp & ~r_rx_sync;

  // Free-running in idle so its strobe also paces the idle detector.
  uart2stream_bitcnt #(
    .WIDTH (CNT_W),
    .RELOAD(DIV)
  ) u_rx_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_en      (1'b1),
    .i_load    (w_rx_load),
    .i_load_val(CNT_W'(DIV / 2)),
    .o_expire  (w_rx_exp)
  );

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RxIdle:  if (w_fall) w_rx_state_nxt = RxStart;
      RxStart: if (w_rx_exp) w_rx_state_nxt = r_rx_sync ? RxIdle : RxData;
      RxData:  if (w_rx_exp && (r_rx_bit == 3'd7)) w_rx_state_nxt = RxStop;
      RxStop:  if (w_rx_exp) w_rx_state_nxt = r_rx_sync ? RxIdle : RxBrk;
      RxBrk:   if (r_rx_sync) w_rx_state_nxt = RxIdle;
      default: w_rx_state_nxt = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RxIdle;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      if ((r_rx_state == RxStart) && w_rx_exp) r_rx_bit <= 3'd0;
      if ((r_rx_state == RxData) && w_rx_exp) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------- RX output + status
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_frame_err, r_overflow;
  logic       w_ovf_set;

  assign w_ovf_set = w_byte_done & r_rx_valid & ~i_rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_byte_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      r_frame_err <= w_frame_err | (r_frame_err & ~i_stat_clr);
      r_overflow  <= w_ovf_set | (r_overflow & ~i_stat_clr);
    end
  end

  // ---------------------------------------------------------------- idle detect
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_inc;
  logic              r_idle_armed, r_rx_idle, w_idle_tick;

  assign w_idle_inc  = r_idle_cnt + IDLE_W'(1);
  assign w_idle_tick = IDLE_EN & (r_rx_state == RxIdle) & w_rx_exp & r_rx_sync & ~w_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt   <= '0;
      r_idle_armed <= 1'b0;
      r_rx_idle    <= 1'b0;
    end else begin
      r_rx_idle <= 1'b0;
      if (w_rx_load) begin
        r_idle_cnt <= '0;
      end else if (w_idle_tick && (r_idle_cnt != IDLE_W'(IDLE_BITS))) begin
        r_idle_cnt <= w_idle_inc;
        if ((w_idle_inc == IDLE_W'(IDLE_BITS)) && r_idle_armed) begin
          r_rx_idle    <= 1'b1;
          r_idle_armed <= 1'b0;
        end
      end
      if (w_byte_done) r_idle_armed <= IDLE_EN;
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_e        r_tx_state, w_tx_state_nxt;
  logic             r_tx_line, r_tx_last;
  logic [8:0]       r_tx_frame;
  logic [3:0]       r_tx_bit;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_tx_exp, w_tx_accept, w_tx_end_bit;

  assign w_tx_accept  = i_tx_valid & (r_tx_state == TxIdle);
  assign w_tx_end_bit = (r_tx_bit == 4'(FRAME_BITS - 1));

  uart2stream_bitcnt #(
    .WIDTH (CNT_W),
    .RELOAD(DIV)
  ) u_tx_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_tx_state != TxIdle),
    .i_load    (w_tx_accept),
    .i_load_val(CNT_W'(DIV)),
    .o_expire  (w_tx_exp)
  );

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TxIdle:  if (w_tx_accept) w_tx_state_nxt = TxShift;
      TxShift: begin
        if (w_tx_exp && w_tx_end_bit) begin
          w_tx_state_nxt = (r_tx_last && (TX_GAP > 0)) ? TxGap : TxIdle;
        end
      end
      TxGap:   if (w_tx_exp && (r_gap_cnt == GAP_W'(TX_GAP - 1))) w_tx_state_nxt = TxIdle;
      default: w_tx_state_nxt = TxIdle;
    endcase
  end

  // r_tx_frame holds the bits still to go out; the start bit is driven directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TxIdle;
      r_tx_line  <= 1'b1;
      r_tx_last  <= 1'b0;
      r_tx_frame <= '1;
      r_tx_bit   <= 4'd0;
      r_gap_cnt  <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_accept) begin
        r_tx_line  <= 1'b0;
        r_tx_frame <= {1'b1, i_tx_data};
        r_tx_last  <= i_tx_last;
        r_tx_bit   <= 4'd0;
        r_gap_cnt  <= '0;
      end else if ((r_tx_state == TxShift) && w_tx_exp && !w_tx_end_bit) begin
        r_tx_line  <= r_tx_frame[0];
        r_tx_frame <= {1'b1, r_tx_frame[8:1]};
        r_tx_bit   <= r_tx_bit + 4'd1;
      end else if ((r_tx_state == TxGap) && w_tx_exp) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign o_uart_tx        = r_tx_line;
  assign o_tx_ready       = (r_tx_state == TxIdle);
  assign o_rx_data        = r_rx_data;
  assign o_rx_valid       = r_rx_valid;
  assign o_rx_idle        = r_rx_idle;
  assign o_stat_frame_err = r_frame_err;
  assign o_stat_overflow  = r_overflow;

endmodule
